// File: rtl/eka_mem_arbiter.sv
// Single-port memory arbiter for the Eka core: sequences instruction fetch, decode hold,
// an optional load/store, and PC advance, and counts retired instructions.
module eka_mem_arbiter #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           mem_wr_data,
  input  logic [3:0]            mem_wr_mask,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  output logic [31:0]           mem_rd_data,
  output logic                  data_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           instret
);

  typedef enum logic [1:0] {FETCH, EXEC, DATA, DONE} state_t;

  state_t      state;
  logic [31:0] inst_q;
  logic [31:0] rdata_q;
  logic [31:0] instret_q;
  logic        xfer;
  logic        data_op;

  function automatic logic [31:0] zext_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] r;
    r = '0;
    r[ADDR_WIDTH-1:0] = a;
    return r;
  endfunction

  assign data_op     = mem_rd | mem_wr;
  assign xfer        = mem_req & mem_ready;
  assign instret     = instret_q;
  assign mem_rd_data = rdata_q;
  assign mem_wdata   = mem_wr_data;

  // Outputs are decoded from state; reset gates them so an access drops in the reset cycle.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = zext_addr(inst_addr);
    mem_wmask   = 4'b0000;
    inst_valid  = 1'b0;
    data_stall  = 1'b0;
    instruction = NOP_INST;
    if (!reset) begin
      case (state)
        FETCH: mem_req = 1'b1;
        EXEC: begin
          inst_valid  = 1'b1;
          instruction = inst_q;
          data_stall  = data_op;
        end
        DATA: begin
          mem_req     = 1'b1;
          mem_we      = mem_wr;
          mem_addr    = data_addr;
          mem_wmask   = mem_wr ? mem_wr_mask : 4'b0000;
          inst_valid  = 1'b1;
          instruction = inst_q;
          data_stall  = 1'b1;
        end
        DONE: begin
          inst_valid  = 1'b1;
          instruction = inst_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      inst_q    <= NOP_INST;
      rdata_q   <= '0;
      instret_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            inst_q <= mem_rdata;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (data_op) begin
            state <= DATA;
          end else begin
            instret_q <= instret_q + 32'd1;
            state     <= FETCH;
          end
        end
        DATA: begin
          if (xfer) begin
            rdata_q <= mem_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          instret_q <= instret_q + 32'd1;
          state     <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
